oam_dma_engine: RTL and testbench

- OAM DMA controller that masters the MMU's DMA request port.
- A CPU write to register 0xFF46 (DMA) starts a 160-byte copy from source XX00–XX9F to OAM at FE00–FE9F.
- While the copy runs, the engine drives a non-0xFFFF DMA address, so the MMU locks the CPU out of OAM and gives the DMA priority on shared memories.
- When the engine is idle it parks the DMA address at 0xFFFF.

---
 rtl/oam_dma_engine.sv | 140 ++++++++++++++
 tb/tb_oam_dma_engine.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_engine.sv
// OAM DMA controller: a write to 0xFF46 copies NUM_BYTES bytes from {src_hi, i} to FE00+i
// through the MMU's DMA port, parking the port at 0xFFFF whenever it is idle.
module oam_dma_engine #(
    parameter int CYCLES_PER_BYTE = 4,
    parameter int READ_LATENCY    = 1,
    parameter int START_DELAY     = 4,
    parameter int NUM_BYTES       = 160
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] mmio_addr_select,
    input  logic [7:0]  mmio_write_value,
    input  logic        mmio_write_enable,
    output logic [7:0]  mmio_read_out,
    output logic [15:0] dma_addr_select,
    output logic [7:0]  dma_write_value,
    output logic        dma_write_enable,
    input  logic [7:0]  dma_read_out,
    output logic        dma_active
);
    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] PARK_ADDR    = 16'hFFFF;
    localparam logic [7:0]  OAM_HI       = 8'hFE;
    localparam logic [7:0]  DELAY_LAST   = 8'(START_DELAY - 1);
    localparam logic [7:0]  PHASE_LAST   = 8'(CYCLES_PER_BYTE - 1);
    localparam logic [7:0]  READ_LAST    = 8'(READ_LATENCY);
    localparam logic [7:0]  WRITE_PHASE  = 8'(READ_LATENCY + 1);
    localparam logic [7:0]  LAST_BYTE    = 8'(NUM_BYTES - 1);

    typedef enum logic [1:0] {IDLE, DELAY, XFER} state_e;

    state_e      state_q, state_d;
    logic [7:0]  reg_q, reg_d;
    logic [7:0]  src_hi_q, src_hi_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  latch_q, latch_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        active_q, active_d;
    logic        trigger;

    assign trigger = mmio_write_enable && (mmio_addr_select == DMA_REG_ADDR);

    always_comb begin
        // NOTE: every _d starts from its _q (or its parked value), so no path through this block infers a latch.
        state_d  = state_q;
        reg_d    = reg_q;
        src_hi_d = src_hi_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        latch_d  = latch_q;
        addr_d   = PARK_ADDR;
        wdata_d  = 8'h00;
        we_d     = 1'b0;
        active_d = (state_q != IDLE);

        case (state_q)
            DELAY: begin
                if (cnt_q == DELAY_LAST) begin
                    state_d = XFER;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            XFER: begin
                addr_d  = (cnt_q <= READ_LAST) ? {src_hi_q, idx_q} : {OAM_HI, idx_q};
                wdata_d = latch_q;
                // Outputs lag the counter by one clock, so the read data for output phase
                // READ_LATENCY is sampled while the counter already shows the write phase.
                if (cnt_q == WRITE_PHASE) begin
                    latch_d = dma_read_out;
                    wdata_d = dma_read_out;
                    we_d    = 1'b1;
                end
                if (cnt_q == PHASE_LAST) begin
                    cnt_d = 8'd0;
                    if (idx_q == LAST_BYTE) begin
                        state_d = IDLE;
                        idx_d   = 8'd0;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: ;
        endcase

        // A trigger wins over everything, abandoning any in-flight byte without writing it.
        if (trigger) begin
            reg_d    = mmio_write_value;
            src_hi_d = (mmio_write_value >= 8'hE0) ? mmio_write_value - 8'h20 : mmio_write_value;
            idx_d    = 8'd0;
            cnt_d    = 8'd0;
            state_d  = DELAY;
            active_d = 1'b1;
            addr_d   = PARK_ADDR;
            wdata_d  = 8'h00;
            we_d     = 1'b0;
        end
    end

    // NOTE: non-blocking assignments make every flop sample pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            reg_q    <= 8'hFF;
            src_hi_q <= 8'h00;
            idx_q    <= 8'd0;
            cnt_q    <= 8'd0;
            latch_q  <= 8'h00;
            addr_q   <= PARK_ADDR;
            wdata_q  <= 8'h00;
            we_q     <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            reg_q    <= reg_d;
            src_hi_q <= src_hi_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            latch_q  <= latch_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            active_q <= active_d;
        end
    end

    assign mmio_read_out    = (mmio_addr_select == DMA_REG_ADDR) ? reg_q : 8'hFF;
    assign dma_addr_select  = addr_q;
    assign dma_write_value  = wdata_q;
    assign dma_write_enable = we_q;
    assign dma_active       = active_q;

endmodule

// File: tb/tb_oam_dma_engine.sv
// Scoreboard bench for oam_dma_engine: stimulus schedules the expected reads, writes and busy
// window of each transfer from the timing rules; a monitor checks every cycle against them.
module tb_oam_dma_engine;
    localparam int CPB        = 4;
    localparam int RL         = 1;
    localparam int START_DLY  = 4;
    localparam int NBYTES     = 160;
    localparam int BUSY_TOTAL = 1 + START_DLY + NBYTES * CPB;

    typedef struct {
        int          t;
        logic [15:0] addr;
        logic [7:0]  data;
    } ev_t;

    logic        clk;
    logic        rst;
    logic [15:0] mmio_addr_select;
    logic [7:0]  mmio_write_value;
    logic        mmio_write_enable;
    logic [7:0]  mmio_read_out;
    logic [15:0] dma_addr_select;
    logic [7:0]  dma_write_value;
    logic        dma_write_enable;
    logic [7:0]  dma_read_out;
    logic        dma_active;

    int  cyc = 0;
    int  n_tests = 0;
    int  n_fail = 0;
    ev_t wq[$];
    ev_t rq[$];
    int  act_lo = 0;
    int  act_hi = 0;
    int  xfer_lo = 0;
    int  wr_count = 0;
    int  act_len = 0;
    int  last_len = 0;

    oam_dma_engine dut (
        .clk               (clk),
        .rst               (rst),
        .mmio_addr_select  (mmio_addr_select),
        .mmio_write_value  (mmio_write_value),
        .mmio_write_enable (mmio_write_enable),
        .mmio_read_out     (mmio_read_out),
        .dma_addr_select   (dma_addr_select),
        .dma_write_value   (dma_write_value),
        .dma_write_enable  (dma_write_enable),
        .dma_read_out      (dma_read_out),
        .dma_active        (dma_active)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Memory behind the MMU: one-clock registered read returning the low address byte ^ 0x5A.
    always @(posedge clk) dma_read_out <= dma_addr_select[7:0] ^ 8'h5A;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Drop every expected event at or after edge a (transfer aborted at that edge).
    task automatic prune(input int a);
        while (wq.size() > 0 && wq[$].t >= a) void'(wq.pop_back());
        while (rq.size() > 0 && rq[$].t >= a) void'(rq.pop_back());
    endtask

    // Reference schedule of one full transfer triggered at edge t0.
    task automatic schedule_run(input logic [7:0] v, input int t0);
        logic [7:0] src;
        int         first_read;
        src = (v >= 8'hE0) ? v - 8'h20 : v;
        prune(t0);
        for (int i = 0; i < NBYTES; i++) begin
            first_read = t0 + START_DLY + 1 + i * CPB;
            for (int r = 0; r <= RL; r++)
                rq.push_back('{first_read + r, {src, 8'(i)}, 8'h00});
            wq.push_back('{first_read + RL + 1, 16'hFE00 + 16'(i), 8'(i) ^ 8'h5A});
        end
        act_lo  = t0;
        act_hi  = t0 + BUSY_TOTAL;
        xfer_lo = t0 + START_DLY + 1;
    endtask

    // Called at a negedge; returns the edge at which the trigger was sampled.
    task automatic do_trigger(input logic [7:0] v, output int t0);
        mmio_addr_select  = 16'hFF46;
        mmio_write_value  = v;
        mmio_write_enable = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        schedule_run(v, t0);
        mmio_write_enable = 1'b0;
        mmio_addr_select  = 16'h0000;
        @(negedge clk);
    endtask

    task automatic wait_idle();
        while (cyc < act_hi + 2) @(negedge clk);
    endtask

    task automatic check_readback(input string name, input logic [7:0] exp);
        mmio_addr_select = 16'hFF46;
        #1;
        check(name, mmio_read_out, exp);
        mmio_addr_select = 16'h0000;
    endtask

    // Monitor: busy window, parking, and every read/write against the scoreboard.
    always @(negedge clk) begin
        ev_t e;
        int  n;
        n = cyc;
        check("dma_active", dma_active, (n >= act_lo && n < act_hi) ? 1 : 0);
        if (dma_active) act_len++;
        else if (act_len != 0) begin
            last_len <= act_len;
            act_len = 0;
        end
        if (!(n >= xfer_lo && n < act_hi)) begin
            check("park_addr", dma_addr_select, 16'hFFFF);
            check("park_we", dma_write_enable, 0);
        end
        if (dma_write_enable) begin
            wr_count++;
            check("write_expected", (wq.size() != 0) ? 1 : 0, 1);
            if (wq.size() != 0) begin
                e = wq.pop_front();
                check("write_addr", dma_addr_select, e.addr);
                check("write_data", dma_write_value, e.data);
                check("write_cycle", n, e.t);
            end
        end else if (dma_addr_select != 16'hFFFF && dma_addr_select[15:8] != 8'hFE) begin
            check("read_expected", (rq.size() != 0) ? 1 : 0, 1);
            if (rq.size() != 0) begin
                e = rq.pop_front();
                check("read_addr", dma_addr_select, e.addr);
                check("read_cycle", n, e.t);
            end
        end
    end

    initial begin
        int          t0;
        int          t1;
        int          base;
        logic [7:0]  v;
        logic [7:0]  v2;
        rst               = 1'b1;
        mmio_addr_select  = 16'h0000;
        mmio_write_value  = 8'h00;
        mmio_write_enable = 1'b0;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_readback("reset_readback", 8'hFF);
        check("reset_addr", dma_addr_select, 16'hFFFF);
        check("reset_active", dma_active, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Plain transfer from C1xx: count writes and busy length.
        base = wr_count;
        do_trigger(8'hC1, t0);
        check_readback("readback_c1", 8'hC1);
        wait_idle();
        check("c1_write_count", wr_count - base, NBYTES);
        check("c1_active_len", last_len, BUSY_TOTAL);

        // Echo RAM source maps down to WRAM.
        do_trigger(8'hE3, t0);
        wait_idle();
        check_readback("readback_e3", 8'hE3);

        // Retrigger exactly on the write clock of byte 50.
        do_trigger(8'h80, t0);
        t1 = t0 + START_DLY + 1 + 50 * CPB + RL + 1;
        while (cyc < t1 - 1) @(negedge clk);
        do_trigger(8'h40, t1);
        wait_idle();
        check_readback("readback_40", 8'h40);

        // Reset in the middle of byte 100, then a clean transfer from page 0.
        v = 8'($urandom_range(0, 255));
        do_trigger(v, t0);
        while (cyc < t0 + START_DLY + 1 + 100 * CPB + 1) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        prune(cyc);
        act_hi = cyc;
        #1;
        check("midreset_addr", dma_addr_select, 16'hFFFF);
        check("midreset_we", dma_write_enable, 0);
        check("midreset_active", dma_active, 0);
        check_readback("midreset_readback", 8'hFF);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_trigger(8'h00, t0);
        wait_idle();
        check_readback("readback_00", 8'h00);

        // Writes elsewhere must not trigger or change the register.
        mmio_addr_select  = 16'hFF47;
        mmio_write_value  = 8'h12;
        mmio_write_enable = 1'b1;
        @(negedge clk);
        mmio_write_enable = 1'b0;
        mmio_addr_select  = 16'hFF40;
        #1 check("other_addr_read", mmio_read_out, 8'hFF);
        check_readback("readback_after_ff47", 8'h00);
        repeat (10) @(negedge clk);

        // Random sources, plus the OAM page that must map to DExx/DFxx.
        for (int k = 0; k < 3; k++) begin
            v = (k == 0) ? 8'hFE : (k == 1) ? 8'hFF : 8'($urandom_range(0, 255));
            do_trigger(v, t0);
            wait_idle();
            check_readback("readback_random", v);
        end

        // Random retrigger point anywhere inside a running transfer.
        v  = 8'($urandom_range(0, 255));
        v2 = 8'($urandom_range(0, 255));
        do_trigger(v, t0);
        t1 = t0 + 1 + int'($urandom_range(0, BUSY_TOTAL - 3));
        while (cyc < t1 - 1) @(negedge clk);
        do_trigger(v2, t1);
        wait_idle();
        check_readback("readback_retrig", v2);

        check("writes_drained", wq.size(), 0);
        check("reads_drained", rq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
